pipeline_stall_controller: RTL and testbench

// - Central sequencer for the 5-stage pipeline's register enables and flushes.
// - Merges the load-use stall request (active-low stalln from the hazard detection unit),
//   the EX-stage branch/jump redirect, and data-memory wait states.
// - Emits per-stage write-enable and flush controls.
// - Tracks multi-cycle memory waits with a timeout; halts the core on a hung memory.
//

---
 rtl/pipeline_stall_controller.sv | 173 +++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Pipeline enable/flush sequencer: merges freeze, branch redirect and load-use stall.
// Define STALL_STATS_EN to add saturating stall_cycles / flush_count statistics outputs.
module pipeline_stall_controller #(
    parameter int unsigned MEM_TIMEOUT = 16
`ifdef STALL_STATS_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stalln,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
`ifdef STALL_STATS_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
`endif
    output logic             halted
);

    localparam int unsigned TO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_we;
        logic mem_wb_we;
        logic halted;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN    = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0,
                                      id_ex_flush: 1'b0, ex_mem_we: 1'b1, mem_wb_we: 1'b1,
                                      halted: 1'b0};
    localparam ctrl_t CTRL_FREEZE = '{default: 1'b0};
    localparam ctrl_t CTRL_BRANCH = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b1,
                                      id_ex_flush: 1'b1, ex_mem_we: 1'b1, mem_wb_we: 1'b1,
                                      halted: 1'b0};
    localparam ctrl_t CTRL_LDUSE  = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                      id_ex_flush: 1'b1, ex_mem_we: 1'b1, mem_wb_we: 1'b1,
                                      halted: 1'b0};

    state_e          state_q, state_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            freeze_c;
    logic            branch_apply_c;
    logic            lduse_apply_c;
    ctrl_t           ctrl_c;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state and wait counter
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (dmem_req && !dmem_ready) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = TO_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q >= TO_MAX) begin
                    state_d = ST_HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Priority decode: freeze > branch > load-use
    always_comb begin
        freeze_c       = ((state_q == ST_RUN) && dmem_req && !dmem_ready) ||
                         ((state_q == ST_MEM_WAIT) && !dmem_ready) ||
                         (state_q == ST_HALT);
        branch_apply_c = rst_n && !freeze_c && branch_taken;
        lduse_apply_c  = rst_n && !freeze_c && !branch_taken && !stalln;
    end

    // Mealy outputs; reset forces the free-running pattern regardless of state
    always_comb begin
        ctrl_c = CTRL_RUN;
        if (rst_n) begin
            if (freeze_c) begin
                ctrl_c        = CTRL_FREEZE;
                ctrl_c.halted = (state_q == ST_HALT);
            end else if (branch_taken) begin
                ctrl_c = CTRL_BRANCH;
            end else if (!stalln) begin
                ctrl_c = CTRL_LDUSE;
            end
        end
    end

    assign pc_we       = ctrl_c.pc_we;
    assign if_id_we    = ctrl_c.if_id_we;
    assign if_id_flush = ctrl_c.if_id_flush;
    assign id_ex_flush = ctrl_c.id_ex_flush;
    assign ex_mem_we   = ctrl_c.ex_mem_we;
    assign mem_wb_we   = ctrl_c.mem_wb_we;
    assign halted      = ctrl_c.halted;

`ifdef STALL_STATS_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    // Saturating event counters
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if ((freeze_c || lduse_apply_c) && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        if (branch_apply_c && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    logic unused_c;
    assign unused_c = branch_apply_c ^ lduse_apply_c;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed self-checking bench for pipeline_stall_controller (MEM_TIMEOUT=4).
module tb_pipeline_stall_controller;

    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int unsigned CNT_W       = 32;

    // {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_we, halted}
    localparam logic [6:0] V_RUN  = 7'b1100110;
    localparam logic [6:0] V_LU   = 7'b0001110;
    localparam logic [6:0] V_BR   = 7'b1111110;
    localparam logic [6:0] V_FRZ  = 7'b0000000;
    localparam logic [6:0] V_HALT = 7'b0000001;

    logic clk;
    logic rst_n, stalln, branch_taken, dmem_req, dmem_ready;
    logic pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_we, halted;
    logic [6:0] obs;
`ifdef STALL_STATS_EN
    logic [CNT_W-1:0] stall_cycles, flush_count;
`endif

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipeline_stall_controller #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
`ifdef STALL_STATS_EN
        ,
        .CNT_W       (CNT_W)
`endif
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stalln       (stalln),
        .branch_taken (branch_taken),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .pc_we        (pc_we),
        .if_id_we     (if_id_we),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_we    (ex_mem_we),
        .mem_wb_we    (mem_wb_we),
`ifdef STALL_STATS_EN
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count),
`endif
        .halted       (halted)
    );

    assign obs = {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, mem_wb_we, halted};

    task automatic set_in(input logic r, input logic s, input logic b, input logic q,
                          input logic y);
        rst_n        = r;
        stalln       = s;
        branch_taken = b;
        dmem_req     = q;
        dmem_ready   = y;
    endtask

    task automatic chk_out(input string tag, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock cycle: outputs checked at the falling edge, inputs change just after rising
    task automatic cyc(input string tag, input logic [6:0] exp);
        @(negedge clk);
        chk_out(tag, exp);
        @(posedge clk);
        #1;
    endtask

`ifdef STALL_STATS_EN
    task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] o,
                           input logic [CNT_W-1:0] exp);
        checks++;
        assert (o === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, o, exp);
        end
    endtask
`endif

    initial begin
        #20000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        // Reset: outputs forced to free-running pattern even with conflicting requests
        cyc("rst_idle", V_RUN);
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc("rst_forced", V_RUN);
`ifdef STALL_STATS_EN
        chk_cnt("rst_stall_cnt", stall_cycles, 0);
        chk_cnt("rst_flush_cnt", flush_count, 0);
`endif
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("idle", V_RUN);

        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("load_use", V_LU);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("lu_release", V_RUN);

        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("branch_and_lu", V_BR);
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("branch_only", V_BR);

        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("ready_no_req", V_RUN);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("ready_no_req_after", V_RUN);

        // Three-cycle memory wait
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc($sformatf("wait3_frz%0d", i), V_FRZ);
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc("wait3_ready", V_RUN);
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("wait3_back_run_lu", V_LU);

        // Ready on wait cycle MEM_TIMEOUT; held branch+stall re-evaluated on release
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc($sformatf("bound_frz%0d", i), V_FRZ);
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        cyc("bound_ready_branch", V_BR);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("bound_run", V_RUN);

        // Timeout: 5th frozen cycle (wait_cnt=4) still not halted, then HALT
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc($sformatf("to_frz%0d", i), V_FRZ);
        cyc("halt", V_HALT);
        cyc("halt_hold", V_HALT);
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc($sformatf("halt_late_ready%0d", i), V_HALT);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("halt_in_reset", V_RUN);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("halt_cleared", V_RUN);

        // Reset mid-wait abandons the access
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc("mid_frz0", V_FRZ);
        cyc("mid_frz1", V_FRZ);
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("mid_reset", V_RUN);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("mid_abandoned", V_RUN);

        // Statistics: 2 load-use + 3 frozen + 1 branch since the last reset
`ifdef STALL_STATS_EN
        chk_cnt("stats_start_stall", stall_cycles, 0);
`endif
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("st_lu0", V_LU);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("st_idle0", V_RUN);
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("st_lu1", V_LU);
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc($sformatf("st_frz%0d", i), V_FRZ);
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc("st_ready", V_RUN);
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc("st_branch", V_BR);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("st_idle1", V_RUN);
`ifdef STALL_STATS_EN
        chk_cnt("stats_stall_cycles", stall_cycles, 5);
        chk_cnt("stats_flush_count", flush_count, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
